// File: rtl/wb_pkg.sv
// Shared types and constants for the integer writeback stage.
package wb_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int REG_IDX_W    = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_IDX_W-1:0]    rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer: circular FIFO with count, full/empty flags and a
// per-slot occupancy vector plus slot rd indices for hazard compares.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  entry_t                           din_i,
    input  logic                             pop_i,
    output entry_t                           head_o,
    output logic [DEPTH-1:0]                 vis_o,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]  vis_rd_o,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        vis_o    = '0;
        vis_rd_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vis_o[i]    = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
            vis_rd_o[i] = mem_q[i].rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: buffers execute results, retires them into the 32-entry
// register file and serves decode reads. WB_BYPASS_EN forwards retiring data.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNT_W = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     wb_stall,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic                     rs1_pending,
    output logic                     rs2_pending,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic [CNT_W-1:0]         retire_count
);

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } entry_t;

    entry_t                          in_ent;
    entry_t                          head;
    logic [DEPTH-1:0]                vis;
    logic [DEPTH-1:0][REG_IDX_W-1:0] vis_rd;
    logic                            full;
    logic                            empty;
    logic                            push;
    logic                            retire;
    logic [XLEN-1:0]                 regs_q [32];
    logic [CNT_W-1:0]                retire_cnt_q;
    logic [CNT_W-1:0]                retire_cnt_d;

    // Handshake: a result transfers on any edge where in_valid && in_ready;
    // in_ready comes from the registered count only, so a full buffer refuses
    // a push even in a cycle where it retires.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign retire   = !empty && !wb_stall;
    assign in_ent   = '{rd: in_rd, data: in_data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i    (CLK),
        .rst_i    (RST),
        .push_i   (push),
        .din_i    (in_ent),
        .pop_i    (retire),
        .head_o   (head),
        .vis_o    (vis),
        .vis_rd_o (vis_rd),
        .count_o  (buf_count),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign retire_cnt_d = retire_cnt_q + CNT_W'(retire);
    assign retire_count = retire_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            retire_cnt_q <= '0;
        end else begin
            if (retire && head.rd != ZERO_REG) begin
                regs_q[head.rd] <= head.data;
            end
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
        if (retire && head.rd == rs1_addr) begin
            rs1_data = head.data;
        end
        if (retire && head.rd == rs2_addr) begin
            rs2_data = head.data;
        end
`endif
        if (rs1_addr == ZERO_REG) begin
            rs1_data = '0;
        end
        if (rs2_addr == ZERO_REG) begin
            rs2_data = '0;
        end
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vis[i] && vis_rd[i] == rs1_addr && rs1_addr != ZERO_REG) begin
                rs1_pending = 1'b1;
            end
            if (vis[i] && vis_rd[i] == rs2_addr && rs2_addr != ZERO_REG) begin
                rs2_pending = 1'b1;
            end
        end
    end

endmodule
